// File: rtl/adder_operand_seq_if.sv
// adder_operand_seq_if: operand stream, adder and result signals of the sequencer
interface adder_operand_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] add_m_o;
  logic [WIDTH-1:0] add_n_o;
  logic [WIDTH:0]   add_sum_i;
  logic [WIDTH:0]   result_o;
  logic             carry_o;
  logic             valid_o;
  logic             ready_i;
  modport slave (
    input  data_i, valid_i, add_sum_i, ready_i,
    output ready_o, add_m_o, add_n_o, result_o, carry_o, valid_o
  );
  modport master (
    output data_i, valid_i, add_sum_i, ready_i,
    input  ready_o, add_m_o, add_n_o, result_o, carry_o, valid_o
  );
endinterface

// File: rtl/adder_operand_seq.sv
// adder_operand_seq: collects M/N bytes, drives the external adder, hands its sum downstream
module adder_operand_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  adder_operand_seq_if.slave bus
);
  typedef enum logic [1:0] {WAIT_M, WAIT_N, CALC, HOLD} state_t;
  state_t           state, state_d;
  logic [WIDTH-1:0] m_q, m_d, n_q, n_d;
  logic [WIDTH:0]   res_q, res_d;
  logic             valid_q, valid_d, ready_q, ready_d;
  logic             in_xfer, out_xfer;
  assign in_xfer      = bus.valid_i & ready_q;
  assign out_xfer     = valid_q & bus.ready_i;
  assign bus.ready_o  = ready_q;
  assign bus.add_m_o  = m_q;
  assign bus.add_n_o  = n_q;
  assign bus.result_o = res_q;
  assign bus.carry_o  = res_q[WIDTH];
  assign bus.valid_o  = valid_q;
  // next state and register updates; clear beats any transfer, result is kept across a flush
  always_comb begin
    state_d = state;
    m_d     = m_q;
    n_d     = n_q;
    res_d   = res_q;
    valid_d = valid_q;
    if (clear_i) begin
      state_d = WAIT_M;
      m_d     = '0;
      n_d     = '0;
      valid_d = 1'b0;
    end else begin
      case (state)
        WAIT_M: begin
          m_d     = in_xfer ? bus.data_i : m_q;
          state_d = in_xfer ? WAIT_N : WAIT_M;
        end
        WAIT_N: begin
          n_d     = in_xfer ? bus.data_i : n_q;
          state_d = in_xfer ? CALC : WAIT_N;
        end
        CALC: begin
          res_d   = bus.add_sum_i;
          valid_d = 1'b1;
          state_d = HOLD;
        end
        HOLD: begin
          valid_d = out_xfer ? 1'b0 : valid_q;
          state_d = out_xfer ? WAIT_M : HOLD;
        end
      endcase
    end
    ready_d = (state_d == WAIT_M) || (state_d == WAIT_N);
  end
  // state and datapath registers; ready comes up one edge after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= WAIT_M;
      m_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: tb/tb_adder_operand_seq.sv
// tb_adder_operand_seq: scoreboard bench for the operand sequencer with a behavioural adder
module tb_adder_operand_seq;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 1'b0;
  int passed = 0;
  int total = 0;
  logic [8:0] q[$];
  logic [8:0] mon_exp;
  adder_operand_seq_if #(.WIDTH(8)) bus();
  adder_operand_seq #(.WIDTH(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .bus    (bus)
  );
  assign bus.add_sum_i = {1'b0, bus.add_m_o} + {1'b0, bus.add_n_o};
  always #5 clk_i = ~clk_i;
  // output monitor: sample mid low phase, the transfer completes at the next rising edge
  always begin
    @(negedge clk_i);
    #2;
    if (rst_ni && !clear_i && bus.valid_o && bus.ready_i) begin
      total++;
      if (q.size() == 0) $display("FAIL unexpected_result: got %h, no result expected", bus.result_o);
      else begin
        mon_exp = q.pop_front();
        if (bus.result_o !== mon_exp || bus.carry_o !== mon_exp[8])
          $display("FAIL result: got %h carry %b, expected %h carry %b", bus.result_o, bus.carry_o, mon_exp, mon_exp[8]);
        else passed++;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic send(input logic [7:0] b);
    int k = 0;
    bus.data_i = b;
    bus.valid_i = 1'b1;
    while (!bus.ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    total++;
    if (!bus.ready_o) $display("FAIL send_ready: ready_o stayed 0 for byte %h", b);
    else passed++;
    @(negedge clk_i);
    bus.valid_i = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk_i);
  endtask
  task automatic wait_valid();
    for (int k = 0; k < 10 && !bus.valid_o; k++) @(negedge clk_i);
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    total++;
    if ({bus.ready_o, bus.valid_o, bus.add_m_o, bus.add_n_o, bus.result_o} !== '0)
      $display("FAIL reset_values: got rdy %b vld %b m %h n %h res %h, expected all 0", bus.ready_o, bus.valid_o, bus.add_m_o, bus.add_n_o, bus.result_o);
    else passed++;
    rst_ni = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b0) $display("FAIL reset_release_ready: got %b expected 0", bus.ready_o);
    else passed++;
    @(negedge clk_i);
    total++;
    if (bus.ready_o !== 1'b1) $display("FAIL reset_ready_rise: got %b expected 1", bus.ready_o);
    else passed++;
    send(8'h33);
    total++;
    if (bus.add_m_o !== 8'h33) $display("FAIL reset_m_capture: got %h expected 33", bus.add_m_o);
    else passed++;
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({bus.ready_o, bus.valid_o, bus.add_m_o, bus.result_o} !== '0)
      $display("FAIL reset_async: got rdy %b vld %b m %h res %h, expected all 0", bus.ready_o, bus.valid_o, bus.add_m_o, bus.result_o);
    else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if (bus.ready_o !== 1'b1) $display("FAIL reset_ready_again: got %b expected 1", bus.ready_o);
    else passed++;
  endtask
  task automatic test_basic();
    bus.ready_i = 1'b1;
    q.push_back(9'h010);
    send(8'h0F);
    send(8'h01);
    total++;
    if (bus.valid_o !== 1'b0) $display("FAIL basic_calc_valid: got %b expected 0", bus.valid_o);
    else passed++;
    @(negedge clk_i);
    total++;
    if (bus.valid_o !== 1'b1 || bus.result_o !== 9'h010 || bus.carry_o !== 1'b0)
      $display("FAIL basic_latency: got vld %b res %h carry %b, expected 1 010 0", bus.valid_o, bus.result_o, bus.carry_o);
    else passed++;
    @(negedge clk_i);
    total++;
    if (bus.valid_o !== 1'b0) $display("FAIL basic_one_cycle: got %b expected 0", bus.valid_o);
    else passed++;
  endtask
  task automatic test_carry();
    bus.ready_i = 1'b1;
    q.push_back(9'h1FE);
    send(8'hFF);
    send(8'hFF);
    drain();
    total++;
    if (bus.carry_o !== 1'b1 || bus.result_o !== 9'h1FE) $display("FAIL carry_ff: got %h carry %b expected 1fe 1", bus.result_o, bus.carry_o);
    else passed++;
    q.push_back(9'h100);
    send(8'h80);
    send(8'h80);
    drain();
    total++;
    if (bus.carry_o !== 1'b1 || bus.result_o !== 9'h100) $display("FAIL carry_80: got %h carry %b expected 100 1", bus.result_o, bus.carry_o);
    else passed++;
  endtask
  task automatic test_backpressure();
    bus.ready_i = 1'b0;
    q.push_back(9'h0A7);
    send(8'h27);
    send(8'h80);
    wait_valid();
    bus.valid_i = 1'b1;
    bus.data_i = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      total++;
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.result_o !== 9'h0A7 || bus.add_m_o !== 8'h27 || bus.add_n_o !== 8'h80)
        $display("FAIL backpressure_hold: got vld %b rdy %b res %h m %h n %h, expected 1 0 0a7 27 80", bus.valid_o, bus.ready_o, bus.result_o, bus.add_m_o, bus.add_n_o);
      else passed++;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    drain();
    q.push_back(9'h007);
    send(8'h03);
    send(8'h04);
    drain();
    total++;
    if (q.size() != 0) $display("FAIL backpressure_drain: got %0d pending, expected 0", q.size());
    else passed++;
  endtask
  task automatic test_gaps();
    bus.ready_i = 1'b1;
    q.push_back(9'h046);
    send(8'h12);
    repeat (3) @(negedge clk_i);
    total++;
    if (bus.ready_o !== 1'b1 || bus.add_m_o !== 8'h12) $display("FAIL gap_retain: got rdy %b m %h, expected 1 12", bus.ready_o, bus.add_m_o);
    else passed++;
    send(8'h34);
    drain();
    total++;
    if (q.size() != 0) $display("FAIL gap_drain: got %0d pending, expected 0", q.size());
    else passed++;
  endtask
  task automatic test_flush();
    bus.ready_i = 1'b1;
    send(8'h55);
    clear_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i = 8'h77;
    @(negedge clk_i);
    clear_i = 1'b0;
    bus.valid_i = 1'b0;
    total++;
    if (bus.add_m_o !== 8'h00 || bus.add_n_o !== 8'h00 || bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0)
      $display("FAIL clear_wait_n: got m %h n %h rdy %b vld %b, expected 00 00 1 0", bus.add_m_o, bus.add_n_o, bus.ready_o, bus.valid_o);
    else passed++;
    q.push_back(9'h003);
    send(8'h01);
    send(8'h02);
    drain();
    total++;
    if (q.size() != 0) $display("FAIL clear_drain: got %0d pending, expected 0", q.size());
    else passed++;
    bus.ready_i = 1'b0;
    send(8'h40);
    send(8'h41);
    wait_valid();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    total++;
    if (bus.valid_o !== 1'b0 || bus.result_o !== 9'h081 || bus.add_m_o !== 8'h00)
      $display("FAIL clear_hold: got vld %b res %h m %h, expected 0 081 00", bus.valid_o, bus.result_o, bus.add_m_o);
    else passed++;
    send(8'h10);
    send(8'h20);
    wait_valid();
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b0 || bus.result_o !== 9'h000) $display("FAIL reset_hold: got vld %b res %h, expected 0 000", bus.valid_o, bus.result_o);
    else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    bus.ready_i = 1'b1;
    q.push_back(9'h002);
    send(8'h01);
    send(8'h01);
    drain();
    total++;
    if (q.size() != 0) $display("FAIL reset_recover: got %0d pending, expected 0", q.size());
    else passed++;
  endtask
  task automatic test_back_to_back();
    logic [7:0] m, n;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m = 8'($urandom_range(0, 255));
      n = 8'($urandom_range(0, 255));
      q.push_back({1'b0, m} + {1'b0, n});
      send(m);
      send(n);
    end
    drain();
    total++;
    if (q.size() != 0) $display("FAIL back_to_back_drain: got %0d pending, expected 0", q.size());
    else passed++;
  endtask
  initial begin
    bus.data_i = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_gaps();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
